// File: rtl/alu_cmd_issuer.sv
// Command issuer in front of the 5-bit signed ALU: filters illegal commands at entry,
// queues legal ones in a small FIFO and issues one per cycle as a registered ALU_en pulse.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [4:0]                 cmd_A,
    input  logic [4:0]                 cmd_B,
    input  logic                       cmd_a_en,
    input  logic [2:0]                 cmd_a_op,
    input  logic                       cmd_b_en,
    input  logic [1:0]                 cmd_b_op,
    input  logic                       alu_hold,
    output logic [4:0]                 A,
    output logic [4:0]                 B,
    output logic                       ALU_en,
    output logic                       a_en,
    output logic [2:0]                 a_op,
    output logic                       b_en,
    output logic [1:0]                 b_op,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       drop_pulse,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 17;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             drop_pulse_q, drop_pulse_d;
    logic             alu_en_q, alu_en_d;
    logic [4:0]       a_q, a_d;
    logic [4:0]       b_q, b_d;
    logic             a_en_q, a_en_d;
    logic [2:0]       a_op_q, a_op_d;
    logic             b_en_q, b_en_d;
    logic [1:0]       b_op_q, b_op_d;

    logic               accept, illegal, push, pop;
    logic [ENTRY_W-1:0] wr_data, head;

    // Ready looks only at occupancy, so a full FIFO refuses entry even on a popping cycle.
    assign cmd_ready = (count_q != OCC_W'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign illegal   = (cmd_a_op == 3'd7)
                    || (cmd_b_en && !cmd_a_en && (cmd_b_op == 2'd3))
                    || (cmd_A == 5'b10000)
                    || (cmd_B == 5'b10000);
    assign push      = accept && !illegal;
    assign pop       = (count_q != '0) && !alu_hold;
    assign wr_data   = {cmd_A, cmd_B, cmd_a_en, cmd_a_op, cmd_b_en, cmd_b_op};
    assign head      = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_pulse_d = accept && illegal;
        drop_cnt_d   = drop_cnt_q;
        alu_en_d     = pop;
        a_d          = a_q;
        b_d          = b_q;
        a_en_d       = 1'b0;
        a_op_d       = 3'd0;
        b_en_d       = 1'b0;
        b_op_d       = 2'd0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            {a_d, b_d, a_en_d, a_op_d, b_en_d, b_op_d} = head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        if (drop_pulse_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            alu_en_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            a_en_q       <= 1'b0;
            a_op_q       <= '0;
            b_en_q       <= 1'b0;
            b_op_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            alu_en_q     <= alu_en_d;
            a_q          <= a_d;
            b_q          <= b_d;
            a_en_q       <= a_en_d;
            a_op_q       <= a_op_d;
            b_en_q       <= b_en_d;
            b_op_q       <= b_op_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign ALU_en     = alu_en_q;
    assign a_en       = a_en_q;
    assign a_op       = a_op_q;
    assign b_en       = b_en_q;
    assign b_op       = b_op_q;
    assign fifo_count = count_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized and directed bench for alu_cmd_issuer against a queue-based reference model;
// a second instance with a 2-bit drop counter exercises saturation on the same stimulus.
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic       a_en;
        logic [2:0] a_op;
        logic       b_en;
        logic [1:0] b_op;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n, cmd_valid, alu_hold;
    cmd_t drv;

    logic       cmd_ready, ALU_en, a_en, b_en, drop_pulse;
    logic [4:0] A, B;
    logic [2:0] a_op, fifo_count;
    logic [1:0] b_op;
    logic [7:0] drop_cnt;

    logic       cmd_ready_s, ALU_en_s, a_en_s, b_en_s, drop_pulse_s;
    logic [4:0] A_s, B_s;
    logic [2:0] a_op_s, fifo_count_s;
    logic [1:0] b_op_s;
    logic [1:0] drop_cnt_s;

    alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(drv.a), .cmd_B(drv.b), .cmd_a_en(drv.a_en), .cmd_a_op(drv.a_op),
        .cmd_b_en(drv.b_en), .cmd_b_op(drv.b_op), .alu_hold(alu_hold),
        .A(A), .B(B), .ALU_en(ALU_en), .a_en(a_en), .a_op(a_op), .b_en(b_en), .b_op(b_op),
        .fifo_count(fifo_count), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
        .cmd_A(drv.a), .cmd_B(drv.b), .cmd_a_en(drv.a_en), .cmd_a_op(drv.a_op),
        .cmd_b_en(drv.b_en), .cmd_b_op(drv.b_op), .alu_hold(alu_hold),
        .A(A_s), .B(B_s), .ALU_en(ALU_en_s), .a_en(a_en_s), .a_op(a_op_s), .b_en(b_en_s),
        .b_op(b_op_s), .fifo_count(fifo_count_s), .drop_pulse(drop_pulse_s), .drop_cnt(drop_cnt_s)
    );

    always #5 clk = ~clk;

    int   tests_run = 0;
    int   fail_cnt  = 0;
    cmd_t model_q[$];
    int   model_drops = 0;
    cmd_t exp_out = '0;
    logic exp_en = 1'b0;
    logic exp_drop = 1'b0;
    logic model_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input int a, input int b, input int ae, input int aop,
                                input int be, input int bop);
        cmd_t c;
        c.a    = a[4:0];
        c.b    = b[4:0];
        c.a_en = ae[0];
        c.a_op = aop[2:0];
        c.b_en = be[0];
        c.b_op = bop[1:0];
        return c;
    endfunction

    function automatic logic is_illegal(input cmd_t c);
        return (c.a_op == 3'd7) || (c.b_en && !c.a_en && c.b_op == 2'd3)
            || ($signed(c.a) == -16) || ($signed(c.b) == -16);
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c = cmd_t'($urandom_range(0, (1 << 17) - 1));
        if ($urandom_range(0, 9) == 0) c.a = 5'b10000;
        if ($urandom_range(0, 9) == 0) c.b = 5'b10000;
        return c;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // One clock: advance the model from pre-edge inputs, then compare every output after the edge.
    task automatic cycle();
        logic acc;
        logic bad;
        if (model_known) begin
            check("cmd_ready", cmd_ready, model_q.size() != DEPTH);
        end
        if (!rst_n) begin
            model_q.delete();
            model_drops = 0;
            exp_en      = 1'b0;
            exp_out     = '0;
            exp_drop    = 1'b0;
            model_known = 1'b1;
        end else begin
            acc = cmd_valid && (model_q.size() != DEPTH);
            bad = is_illegal(drv);
            if (model_q.size() != 0 && !alu_hold) begin
                exp_out = model_q.pop_front();
                exp_en  = 1'b1;
            end else begin
                exp_en       = 1'b0;
                exp_out.a_en = 1'b0;
                exp_out.a_op = 3'd0;
                exp_out.b_en = 1'b0;
                exp_out.b_op = 2'd0;
            end
            exp_drop = acc && bad;
            if (acc && bad) model_drops++;
            else if (acc) model_q.push_back(drv);
        end
        @(posedge clk);
        #1;
        check("ALU_en", ALU_en, exp_en);
        check("A", A, exp_out.a);
        check("B", B, exp_out.b);
        check("a_en", a_en, exp_out.a_en);
        check("a_op", a_op, exp_out.a_op);
        check("b_en", b_en, exp_out.b_en);
        check("b_op", b_op, exp_out.b_op);
        check("fifo_count", fifo_count, model_q.size());
        check("drop_pulse", drop_pulse, exp_drop);
        check("drop_cnt", drop_cnt, sat(model_drops, 255));
        check("drop_cnt_sat2", drop_cnt_s, sat(model_drops, 3));
        check("inv_a_op7", a_op == 3'd7, 0);
        check("inv_b_op3", b_en && !a_en && b_op == 2'd3, 0);
        check("inv_m16", ALU_en && (A == 5'b10000 || B == 5'b10000), 0);
        if (ALU_en) begin
            $display("[TB] issue A=%0d B=%0d a_en=%0b a_op=%0d b_en=%0b b_op=%0d",
                     $signed(A), $signed(B), a_en, a_op, b_en, b_op);
        end
    endtask

    task automatic push_cmd(input cmd_t c);
        cmd_valid = 1'b1;
        drv       = c;
        cycle();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        alu_hold  = 1'b0;
        drv       = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single issue: visible one edge after acceptance, A holds afterwards.
        push_cmd(mk(5, -3, 1, 0, 0, 0));
        cycle();
        check("single_en", ALU_en, 1);
        check("single_B", B, 5'b11101);
        cycle();
        check("single_en_off", ALU_en, 0);
        check("single_A_hold", A, 5);

        // Backpressure: five offered under hold, four stored.
        alu_hold = 1'b1;
        for (int i = 0; i < 5; i++) push_cmd(mk(i + 1, i, 1, i, 1, i % 4));
        check("full_count", fifo_count, DEPTH);
        check("full_ready", cmd_ready, 0);
        alu_hold = 1'b0;
        repeat (5) cycle();
        check("drain_ready", cmd_ready, 1);

        // Illegal filtering.
        push_cmd(mk(1, 1, 1, 7, 0, 0));
        push_cmd(mk(1, 1, 0, 0, 1, 3));
        push_cmd(mk(-16, 1, 1, 0, 0, 0));
        push_cmd(mk(0, 2, 1, 1, 0, 0));
        repeat (3) cycle();
        check("filter_drops", drop_cnt, 3);

        // Simultaneous push/pop at count 2, then wrap with pops.
        alu_hold = 1'b1;
        push_cmd(mk(3, 4, 1, 2, 0, 0));
        push_cmd(mk(6, 7, 0, 0, 1, 1));
        alu_hold = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(mk(i, -i, 1, 3, 1, 2));
        check("pushpop_count", fifo_count, 2);
        repeat (3) cycle();

        // Reset mid-stream with three queued.
        alu_hold = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(mk(9, 9 - i, 1, 1, 0, 0));
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n    = 1'b1;
        alu_hold = 1'b0;
        repeat (3) cycle();
        check("rst_count", fifo_count, 0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) push_cmd(mk(-16, i, 1, 0, 0, 0));
        cycle();
        check("sat_cnt2", drop_cnt_s, 3);
        check("sat_cnt8", drop_cnt, 5);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            cmd_valid = ($urandom_range(0, 3) != 0);
            alu_hold  = ($urandom_range(0, 3) == 0);
            drv       = rand_cmd();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Upstream stage of the 5-bit signed ALU.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle onto the ALU operand/control pins as a one-cycle ALU_en pulse.
- Legalises traffic at entry: commands the ALU must never see are dropped and counted, so the ALU input pins never carry them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  upstream command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_A  input  5  signed operand A.
- cmd_B  input  5  signed operand B.
- cmd_a_en  input  1  A-group enable.
- cmd_a_op  input  3  A-group opcode.
- cmd_b_en  input  1  B-group enable.
- cmd_b_op  input  2  B-group opcode.
- alu_hold  input  1  stall: when 1, no issue this cycle.
- A  output  5  signed operand to ALU, registered.
- B  output  5  signed operand to ALU, registered.
- ALU_en  output  1  issue strobe, registered.
- a_en  output  1  registered.
- a_op  output  3  registered.
- b_en  output  1  registered.
- b_op  output  2  registered.
- fifo_count  output  $clog2(DEPTH)+1  occupancy.
- drop_pulse  output  1  one-cycle pulse, registered; an illegal command was dropped.
- drop_cnt  output  CNT_W  saturating count of dropped commands.

Behaviour:
- Reset: while rst_n=0 at a clk edge, all of the following go to 0:
  - FIFO pointers, fifo_count, drop_cnt, drop_pulse.
  - ALU_en, a_en, b_en, a_op, b_op, A, B.
- Reset mid-operation discards all queued commands; no partial issue follows.
- cmd_ready is combinational: cmd_ready = (fifo_count != DEPTH).
  - It does not depend on a same-cycle pop, so a full FIFO refuses entry even when popping.
- Accept: a handshake occurs when cmd_valid && cmd_ready at a clk edge.
- Illegal command, evaluated on the accepted command. Any one of these makes it illegal:
  - cmd_a_op==7 (regardless of cmd_a_en).
  - cmd_b_en && !cmd_a_en && cmd_b_op==3.
  - cmd_A==-16 or cmd_B==-16.
- Illegal commands are consumed (handshake completes) but not written:
  - drop_pulse=1 on the next cycle.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- Legal commands are written at the write pointer; the pointer wraps modulo DEPTH.
- Issue occurs when the FIFO is non-empty and alu_hold=0 at a clk edge:
  - Head entry is popped.
  - After that edge: ALU_en=1 and A, B, a_en, a_op, b_en, b_op = entry fields.
- No issue (empty FIFO or alu_hold=1):
  - After the edge: ALU_en=0, a_en=0, b_en=0, a_op=0, b_op=0.
  - A and B hold their previous value.
- Latency: a legal command accepted at edge k into an empty FIFO appears on the ALU pins after edge k+1 (earliest).
- Throughput: back-to-back issues give consecutive ALU_en=1 cycles, one command per cycle.
- Simultaneous push and pop on the same edge (non-full): fifo_count unchanged.
- Ordering: strict FIFO; dropped commands create no gap in the issued stream.
- Invariants guaranteed on the outputs:
  - a_op never equals 7.
  - b_op never equals 3 while b_en && !a_en.
  - A and B never equal -16 while ALU_en=1.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-stream with 3 entries queued -> fifo_count=0, ALU_en=0, and no stale issue after rst_n=1.
- Single issue: push A=5, B=-3, a_en=1, a_op=0 at edge 10 -> after edge 11: ALU_en=1, A=5, B=-3, a_op=0; after edge 12: ALU_en=0, A still 5.
- Full/backpressure:
  - alu_hold=1, push 5 commands -> 4 accepted, cmd_ready=0 with fifo_count=4.
  - Release hold -> 4 consecutive ALU_en pulses in push order, then cmd_ready=1.
- Illegal filtering: push, in order:
  - a_op=7
  - b_en=1, a_en=0, b_op=3
  - A=-16
  - legal B=2 command

  -> 3 drop_pulses, drop_cnt=3, and only the B=2 command is issued.
- Simultaneous push/pop at count=2 -> count stays 2; after 4 further pushes with pops, pointer wrap keeps order intact.
- Saturation: with CNT_W=2, drop 5 illegal commands -> drop_cnt=3.
